state_dump_unit: RTL
====================

# state_dump_unit

Synthesizable successor to the end-of-simulation state dump used on the processor bench. On a `start` pulse, it walks the register file and then the first `DMEM_BYTES` bytes of data memory. It assembles little-endian words and streams every entry out over a valid/ready channel. It sits beside `processador`, attached to spare read ports of the register file and data memory, so the same dump is available on silicon/FPGA and in any simulator without hierarchical references.

## Interface
- `XLEN`, 32: data word width in bits; multiple of 8.
- `NREGS`, 32: register count dumped, indices 0..NREGS-1.
- `REG_AW`, 5: register address width; 2^REG_AW >= NREGS.
- `DMEM_BYTES`, 32: bytes of data memory dumped, starting at byte address 0.
- `DMEM_AW`, 32: data-memory byte address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a dump; sampled only in IDLE.
- `reg_raddr` out REG_AW: register file read address.
- `reg_rdata` in XLEN: combinational read data for `reg_raddr`.
- `dmem_raddr` out DMEM_AW: data memory byte read address.
- `dmem_rdata` in 8: combinational read byte for `dmem_raddr`.
- `out_valid` out 1: beat present.
- `out_ready` in 1: consumer accepts the beat when high with `out_valid`.
- `out_tag` out 2: 00 register, 01 memory word, 10 checksum.
- `out_index` out DMEM_AW: register number, or byte address of the memory word's byte 0.
- `out_data` out XLEN: beat payload.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, REGS, MEM_GATHER, MEM_EMIT, then CSUM (only with the macro), then back to IDLE.
- IDLE to REGS: on `start`=1; the index counter clears to 0. `start` outside IDLE is ignored.
- REGS:
  - Drive `reg_raddr`=idx.
  - When the output register is empty, or its beat is being accepted this cycle, load {tag 00, index idx, `reg_rdata`} and increment idx.
  - After idx NREGS-1 is loaded, go to MEM_GATHER with the byte counter cleared.
- MEM_GATHER:
  - Runs BPW=XLEN/8 cycles per word; cycle k drives `dmem_raddr`=base+k.
  - Byte k is latched into bits [8k+7:8k].
  - Bytes at addresses >= DMEM_BYTES are not read; they are zero-filled and `dmem_raddr` holds the last valid address.
  - Gathering waits while the output register still holds an unaccepted beat.
  - After byte BPW-1, go to MEM_EMIT.
- MEM_EMIT:
  - Load {tag 01, index base, word} into the output register and add BPW to base.
  - If base+BPW < DMEM_BYTES, return to MEM_GATHER; otherwise go to CSUM or to the final drain.
- Drain: once the last beat handshakes, pulse `done` and return to IDLE.
- Width rules:
  - `out_index` is zero-extended.
  - Register reads of idx >= 2^REG_AW never occur, because that parameter combination is illegal.
- Handshake:
  - `out_valid`, once high, stays high with `out_tag`/`out_index`/`out_data` stable until `out_ready`=1.
  - No beat is dropped or duplicated.
- Reset (`rst`=0 at a clock edge), including mid-dump:
  - State to IDLE, all counters to 0.
  - `out_valid`=0, `busy`=0, `done`=0, `reg_raddr`=0, `dmem_raddr`=0, `out_tag`=0, `out_index`=0, `out_data`=0.

## Timing
- Start is sampled at edge E0. The first register beat has `out_valid`=1 after E1, registered from `reg_rdata` during cycle E0–E1.
- With `out_ready` held 1: one register beat per cycle, NREGS consecutive beats.
- Memory phase with `out_ready` held 1: one word beat every BPW+1 cycles.
- `done` asserts the cycle after the final handshake. `busy` falls in the same cycle.
- `reg_rdata`/`dmem_rdata` must settle within the cycle the address is driven; there is no wait-state support.

## Configuration
- `STATE_DUMP_CHECKSUM_EN` defined:
  - After the last memory beat, the unit emits one extra beat {tag 10, index 0, data}.
  - The checksum data is the mod-2^XLEN sum of every preceding `out_data` in this dump.
  - The accumulator clears on `start`.
- Macro undefined:
  - No CSUM state and no accumulator.
  - Tag 10 is never produced; the dump ends with the last memory beat.

## Test plan
- Register sweep:
  - Setup: regfile x[i]=i*3, DMEM_BYTES=32, `out_ready`=1, pulse `start`.
  - Response: beats 0..31 carry tag 00, index i, data i*3, on consecutive cycles.
- Little-endian words:
  - Setup: mem[0..3]=78,56,34,12.
  - Response: the first tag-01 beat has index 0 and data 0x12345678; 8 memory beats follow, indices 0,4,…,28.
- Backpressure:
  - Setup: toggle `out_ready` 1/0 every cycle during the dump.
  - Response: beat sequence is identical to the stall-free run; `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Partial tail:
  - Setup: DMEM_BYTES=6, mem[4..5]=AA,BB.
  - Response: the final memory beat is index 4, data 0x0000BBAA; `done` pulses once.
- Reset mid-dump and ignored start:
  - Setup: `rst`=0 during register beat 10, then `start` again.
  - Response: `out_valid`=0 and `busy`=0 after the reset edge; the new dump restarts from x0. A `start` pulsed while `busy`=1 has no effect.
- Checksum (with `STATE_DUMP_CHECKSUM_EN`):
  - Setup: all regs 1, all mem bytes 0.
  - Response: the last beat is tag 10, data 0x00000020. Without the macro, the beat count is 40.

Source files
------------

// File: rtl/state_dump_unit.sv
// state_dump_unit: walks the register file, then data memory, streaming
// every entry as a valid/ready beat. Define STATE_DUMP_CHECKSUM_EN for a trailing checksum beat.
module state_dump_unit #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int REG_AW     = 5,
    parameter int DMEM_BYTES = 32,
    parameter int DMEM_AW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [REG_AW-1:0]  reg_raddr,
    input  logic [XLEN-1:0]    reg_rdata,
    output logic [DMEM_AW-1:0] dmem_raddr,
    input  logic [7:0]         dmem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_tag,
    output logic [DMEM_AW-1:0] out_index,
    output logic [XLEN-1:0]    out_data,
    output logic               busy,
    output logic               done
);

    localparam int BPW = XLEN / 8;
    localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [DMEM_AW:0]   LIMIT     = (DMEM_AW+1)'(DMEM_BYTES);
    localparam logic [DMEM_AW:0]   BPW_EXT   = (DMEM_AW+1)'(BPW);
    localparam logic [DMEM_AW-1:0] LAST_ADDR = DMEM_AW'(DMEM_BYTES - 1);
    localparam logic [REG_AW-1:0]  LAST_REG  = REG_AW'(NREGS - 1);
    localparam logic [KW-1:0]      LAST_BYTE = KW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        REGS,
        MEM_GATHER,
        MEM_EMIT,
`ifdef STATE_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DRAIN
    } state_e;

    state_e             state_q;
    logic [REG_AW-1:0]  idx_q;
    logic [KW-1:0]      k_q;
    logic [DMEM_AW-1:0] base_q;
    logic [XLEN-1:0]    word_q;
    logic               ov_q;
    logic [1:0]         tag_q;
    logic [DMEM_AW-1:0] index_q;
    logic [XLEN-1:0]    data_q;
    logic               done_q;
`ifdef STATE_DUMP_CHECKSUM_EN
    logic [XLEN-1:0]    csum_q;
`endif

    logic               accept;
    logic               can_load;
    logic [DMEM_AW:0]   addr_ext;
    logic [DMEM_AW:0]   base_d;
    logic               in_range;
    logic               more_d;
    logic [7:0]         byte_d;

    assign accept   = ov_q & out_ready;
    assign can_load = ~ov_q | out_ready;
    assign addr_ext = {1'b0, base_q} + {{(DMEM_AW+1-KW){1'b0}}, k_q};
    assign base_d   = {1'b0, base_q} + BPW_EXT;
    assign in_range = addr_ext < LIMIT;
    assign more_d   = base_d < LIMIT;
    assign byte_d   = in_range ? dmem_rdata : 8'h00;

    assign reg_raddr  = idx_q;
    assign dmem_raddr = (state_q != MEM_GATHER) ? '0 :
                        in_range ? addr_ext[DMEM_AW-1:0] : LAST_ADDR;
    assign out_valid  = ov_q;
    assign out_tag    = tag_q;
    assign out_index  = index_q;
    assign out_data   = data_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    // Dump sequencer plus the single-entry output register it feeds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            base_q  <= '0;
            word_q  <= '0;
            ov_q    <= 1'b0;
            tag_q   <= 2'b00;
            index_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef STATE_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                ov_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= REGS;
                        idx_q   <= '0;
                        k_q     <= '0;
                        base_q  <= '0;
`ifdef STATE_DUMP_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                REGS: begin
                    if (can_load) begin
                        ov_q    <= 1'b1;
                        tag_q   <= 2'b00;
                        index_q <= DMEM_AW'(idx_q);
                        data_q  <= reg_rdata;
`ifdef STATE_DUMP_CHECKSUM_EN
                        csum_q  <= csum_q + reg_rdata;
`endif
                        if (idx_q == LAST_REG) begin
                            state_q <= MEM_GATHER;
                            k_q     <= '0;
                            base_q  <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                MEM_GATHER: begin
                    if (can_load) begin
                        word_q[8*k_q +: 8] <= byte_d;
                        if (k_q == LAST_BYTE) begin
                            k_q     <= '0;
                            state_q <= MEM_EMIT;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                MEM_EMIT: begin
                    if (can_load) begin
                        ov_q    <= 1'b1;
                        tag_q   <= 2'b01;
                        index_q <= base_q;
                        data_q  <= word_q;
                        base_q  <= base_d[DMEM_AW-1:0];
`ifdef STATE_DUMP_CHECKSUM_EN
                        csum_q  <= csum_q + word_q;
                        state_q <= more_d ? MEM_GATHER : CSUM;
`else
                        state_q <= more_d ? MEM_GATHER : DRAIN;
`endif
                    end
                end
`ifdef STATE_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (can_load) begin
                        ov_q    <= 1'b1;
                        tag_q   <= 2'b10;
                        index_q <= '0;
                        data_q  <= csum_q;
                        state_q <= DRAIN;
                    end
                end
`endif
                DRAIN: begin
                    if (accept) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
